// File: rtl/demodulate_pipe.sv
// demodulate_pipe: FM quadrature demodulator stage.
// Per accepted I/Q sample: conjugate product with the previous sample,
// quantised arctangent via a serial restoring divider, then a fixed gain.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is only high in IDLE; out_valid is held in OUT with
// demod_out stable until out_ready is seen high, and it drops the next cycle.
module demodulate_pipe #(
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 10,
  parameter int GAIN       = 758,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412,
  parameter int SKIP_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] real_in,
  input  logic signed [DATA_W-1:0] imag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] demod_out
);

  localparam int W  = DATA_W + 1;               // numerator/denominator base width
  localparam int QW = DATA_W + FRAC_BITS + 2;   // quotient width = divide cycles
  localparam int PW = 2 * DATA_W;               // full product width
  localparam int CW = $clog2(QW);

  localparam logic signed [PW-1:0]     GAIN_P   = PW'(GAIN);
  localparam logic signed [PW-1:0]     Q1_P     = PW'(QUAD1);
  localparam logic signed [DATA_W-1:0] Q1_D     = DATA_W'(QUAD1);
  localparam logic signed [DATA_W-1:0] Q3_D     = DATA_W'(QUAD3);
  localparam logic signed [PW-1:0]     DEQ_BIAS = PW'((1 << FRAC_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_DIV   = 3'd2,
    S_ANGLE = 3'd3,
    S_SCALE = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_W-1:0] r_rc, r_ic;      // current sample
  logic signed [DATA_W-1:0] r_rp, r_ip;      // previous sample (history)
  logic                     r_x_neg, r_y_neg;
  logic        [QW-1:0]     r_nmag;          // |num|, shifted out MSB first
  logic        [QW-1:0]     r_den;
  logic        [QW-1:0]     r_rem;
  logic        [QW-1:0]     r_q;
  logic                     r_qneg;
  logic        [CW-1:0]     r_cnt;
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_first;
  logic                     r_ready_en;      // keeps in_ready low until the first clock after reset

  // Sign-extend a DATA_W value to the full product width.
  function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] v);
    sext = {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  // Dequantise: divide by 2^FRAC_BITS, truncating toward zero.
  function automatic logic signed [PW-1:0] deq(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t   = v + (v[PW-1] ? DEQ_BIAS : '0);
    deq = t >>> FRAC_BITS;
  endfunction

  // Conjugate product, wrapping in DATA_W like C int arithmetic.
  logic signed [DATA_W-1:0] w_x, w_y;
  logic                     w_x_neg, w_y_neg;
  logic signed [W-1:0]      w_x_ext, w_y_ext, w_ay, w_nbase;
  logic        [W-1:0]      w_den;
  logic signed [QW-1:0]     w_num;
  logic        [QW-1:0]     w_nmag;

  assign w_x     = r_rp * r_rc + r_ip * r_ic;
  assign w_y     = r_rp * r_ic - r_ip * r_rc;
  assign w_x_neg = w_x[DATA_W-1];
  assign w_y_neg = w_y[DATA_W-1];
  assign w_x_ext = {w_x[DATA_W-1], w_x};
  assign w_y_ext = {w_y[DATA_W-1], w_y};
  // |y| + 1 in W bits so the most negative y cannot overflow; also makes den >= 1.
  assign w_ay    = (w_y_neg ? -w_y_ext : w_y_ext) + W'(1);
  assign w_nbase = w_x_neg ? (w_x_ext + w_ay) : (w_x_ext - w_ay);
  assign w_den   = w_x_neg ? (w_ay - w_x_ext) : (w_x_ext + w_ay);
  assign w_num   = QW'(w_nbase) << FRAC_BITS;
  assign w_nmag  = w_num[QW-1] ? -w_num : w_num;

  // One restoring-division step per DIV cycle.
  logic [QW:0]   w_rem_sh;
  logic          w_ge;
  logic [QW-1:0] w_rem_nx;

  assign w_rem_sh = {r_rem, r_nmag[QW-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_den});
  assign w_rem_nx = w_ge ? QW'(w_rem_sh - {1'b0, r_den}) : QW'(w_rem_sh);

  // Angle from the signed quotient, then gain.
  logic signed [DATA_W-1:0] w_r, w_base, w_a0, w_a, w_scaled;
  logic signed [PW-1:0]     w_pa, w_ps;

  assign w_r      = DATA_W'(r_qneg ? -r_q : r_q);
  assign w_pa     = sext(w_r) * Q1_P;
  assign w_base   = r_x_neg ? Q3_D : Q1_D;
  assign w_a0     = w_base - DATA_W'(deq(w_pa));
  assign w_a      = r_y_neg ? -w_a0 : w_a0;
  assign w_ps     = sext(r_a) * GAIN_P;
  assign w_scaled = DATA_W'(deq(w_ps));

  assign in_ready  = (r_state == S_IDLE) && r_ready_en;
  assign out_valid = (r_state == S_OUT);
  assign demod_out = r_out;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; clear wins over everything, including in_valid.
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (in_valid && in_ready) w_next = S_MULT;
        S_MULT:  w_next = S_DIV;
        S_DIV:   if (r_cnt == CW'(QW - 1)) w_next = S_ANGLE;
        S_ANGLE: w_next = S_SCALE;
        S_SCALE: w_next = ((SKIP_FIRST != 0) && r_first) ? S_IDLE : S_OUT;
        S_OUT:   if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath registers, sequenced by the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rc       <= '0;
      r_ic       <= '0;
      r_rp       <= '0;
      r_ip       <= '0;
      r_x_neg    <= 1'b0;
      r_y_neg    <= 1'b0;
      r_nmag     <= '0;
      r_den      <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_qneg     <= 1'b0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_out      <= '0;
      r_first    <= 1'b1;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (clear) begin
        r_rp    <= '0;
        r_ip    <= '0;
        r_first <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid && in_ready) begin
              r_rc <= real_in;
              r_ic <= imag_in;
            end
          end
          S_MULT: begin
            r_rp    <= r_rc;
            r_ip    <= r_ic;
            r_x_neg <= w_x_neg;
            r_y_neg <= w_y_neg;
            r_nmag  <= w_nmag;
            r_den   <= QW'(w_den);
            r_qneg  <= w_num[QW-1];
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
          end
          S_DIV: begin
            r_rem  <= w_rem_nx;
            r_q    <= {r_q[QW-2:0], w_ge};
            r_nmag <= r_nmag << 1;
            r_cnt  <= r_cnt + 1'b1;
          end
          S_ANGLE: r_a <= w_a;
          S_SCALE: begin
            r_out   <= w_scaled;
            r_first <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demodulate_pipe.sv
// Testbench for demodulate_pipe: one instance without and one with
// first-sample suppression, driven from a vector table plus corner sequences.
module tb_demodulate_pipe;

  localparam int DW  = 32;
  localparam int LAT = 47;   // accept edge -> out_valid
  localparam int THR = 49;   // accept-to-accept spacing with out_ready high

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 rst[2], clr[2], in_valid[2], in_ready[2];
  logic                 out_valid[2], out_ready[2];
  logic signed [DW-1:0] re_in[2], im_in[2], dout[2];

  int checks = 0, failures = 0;
  int acc_cyc = 0, prev_acc = 0;
  logic [DW-1:0] exp_q[$];
  vec_t vecs[9];

  demodulate_pipe #(.SKIP_FIRST(0)) dut0 (
    .clk(clk), .reset(rst[0]), .clear(clr[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .real_in(re_in[0]), .imag_in(im_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .demod_out(dout[0])
  );

  demodulate_pipe #(.SKIP_FIRST(1)) dut1 (
    .clk(clk), .reset(rst[1]), .clear(clr[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .real_in(re_in[1]), .imag_in(im_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .demod_out(dout[1])
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut(input int u);
    @(negedge clk);
    rst[u] = 1'b1; in_valid[u] = 1'b0; clr[u] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready[u], 0);
    chk("rst_out_valid", out_valid[u], 0);
    chk("rst_demod_out", dout[u], 0);
    rst[u] = 1'b0;
    #1 chk("rst_release_in_ready", in_ready[u], 0);
    @(negedge clk);
    chk("rst_ready_rise", in_ready[u], 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int u, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    int n = 0;
    while (!in_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) begin
      chk("in_ready_wait", in_ready[u], 1);
      return;
    end
    in_valid[u] = 1'b1; re_in[u] = re; im_in[u] = im;
    @(negedge clk);
    in_valid[u] = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
  endtask

  task automatic expect_out(input int u, input string name, input int hold);
    int lat = 0;
    int bad = 0;
    logic signed [DW-1:0] e;
    e = exp_q.pop_front();
    while (!out_valid[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_valid"}, out_valid[u], 1);
    if (!out_valid[u]) return;
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_data"}, dout[u], e);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (out_valid[u] !== 1'b1 || dout[u] !== e || in_ready[u] !== 1'b0) bad++;
      end
      chk({name, "_hold_bad_cycles"}, bad, 0);
      out_ready[u] = 1'b1;
    end
    @(negedge clk);
    chk({name, "_drop"}, out_valid[u], 0);
  endtask

  task automatic expect_none(input int u, input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid[u]) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic abort_mid_div(input int u, input bit use_reset);
    send(u, 0, 1024);
    repeat (10) @(negedge clk);
    if (use_reset) rst[u] = 1'b1; else clr[u] = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid[u], 0);
    rst[u] = 1'b0; clr[u] = 1'b0;
    expect_none(u, use_reset ? "rst_mid_div_no_out" : "clr_mid_div_no_out", 60);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; clr[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b1;
      re_in[u] = '0; im_in[u] = '0;
    end

    reset_dut(0);
    reset_dut(1);

    // Applied back to back; each row's result depends on the previous row.
    vecs[0] = '{re: 1024,  im: 0,     exp: 1190};   // prev = 0: x = y = 0
    vecs[1] = '{re: 1024,  im: 0,     exp: 0};      // constant phase
    vecs[2] = '{re: 0,     im: 1024,  exp: 1190};   // +90 deg
    vecs[3] = '{re: 1024,  im: 0,     exp: -1190};  // -90 deg
    vecs[4] = '{re: 0,     im: -1024, exp: -1190};  // -90 deg
    vecs[5] = '{re: 1024,  im: 0,     exp: 1190};   // +90 deg
    vecs[6] = '{re: -1024, im: 0,     exp: 2379};   // x < 0 path
    vecs[7] = '{re: -1024, im: 0,     exp: 0};      // constant phase
    vecs[8] = '{re: 0,     im: 0,     exp: 1190};   // zero sample

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vecs[i].exp);
      send(0, vecs[i].re, vecs[i].im);
      if (i > 0) chk($sformatf("vec%0d_throughput", i), acc_cyc - prev_acc, THR);
      expect_out(0, $sformatf("vec%0d", i), 0);
    end

    // clear mid-DIV: history dropped, otherwise the next result would be -1190
    abort_mid_div(0, 1'b0);
    chk("clr_idle_in_ready", in_ready[0], 1);
    exp_q.push_back(1190);
    send(0, 1024, 0);
    expect_out(0, "after_clr", 0);

    // clear together with in_valid in IDLE: sample must not be accepted
    clr[0] = 1'b1; in_valid[0] = 1'b1; re_in[0] = 1024; im_in[0] = 0;
    @(negedge clk);
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    chk("clr_vs_valid_in_ready", in_ready[0], 1);
    expect_none(0, "clr_vs_valid_no_out", 60);
    exp_q.push_back(1190);     // prev cleared; stale prev (1024,0) would give 0
    send(0, 1024, 0);
    expect_out(0, "after_clr_idle", 0);

    // reset mid-DIV
    abort_mid_div(0, 1'b1);
    exp_q.push_back(1190);
    send(0, 1024, 0);
    expect_out(0, "after_rst_mid", 0);

    // first-sample suppression
    send(1, 1024, 0);
    expect_none(1, "skip_first_no_out", 60);
    exp_q.push_back(0);
    send(1, 1024, 0);
    expect_out(1, "skip_second", 0);
    exp_q.push_back(1190);
    out_ready[1] = 1'b0;
    send(1, 0, 1024);
    expect_out(1, "skip_hold", 20);

    // reset mid-DIV with suppression: next sample counts as first again
    abort_mid_div(1, 1'b1);
    send(1, 1024, 0);
    expect_none(1, "rst_mid1_first_skipped", 60);
    exp_q.push_back(0);
    send(1, 1024, 0);
    expect_out(1, "rst_mid1_second", 0);

    // clear mid-DIV with suppression: first flag set again
    abort_mid_div(1, 1'b0);
    send(1, 1024, 0);
    expect_none(1, "clr_mid1_first_skipped", 60);
    exp_q.push_back(0);
    send(1, 1024, 0);
    expect_out(1, "clr_mid1_second", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
